seq_detector_param: RTL

- Parametrised serial bit-pattern detector. Successor to the fixed single-pattern detector.
- Adds runtime-programmable pattern and length, overlap/non-overlap mode, an input-valid qualifier and a saturating match counter.
- Sits on a serial input stream. Emits a one-cycle registered pulse per pattern occurrence.

---
 rtl/seq_detector_param_if.sv | 29 ++
 rtl/seq_detector_param.sv | 118 +++++++++++
 2 files changed

// File: rtl/seq_detector_param_if.sv
// Bundle of serial-stream, configuration and result signals for seq_detector_param.
// The master side drives stream/config; the slave side is the detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               detected;
    logic               armed;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  detected, armed, match_cnt
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output detected, armed, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// input qualifier and saturating match counter. All outputs registered.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0011_1111,
    parameter int                 DEF_LEN     = 6,
    parameter logic               DEF_OVERLAP = 1'b1
) (
    input logic                clk,
    input logic                rstn,
    seq_detector_param_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               detected_q, detected_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] mask_s;
    logic [MAX_LEN-1:0] hist_shift_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic               match_s;

    // Next-state logic: config load beats stream input; counter clear beats a match.
    always_comb begin
        pattern_d    = pattern_q;
        len_d        = len_q;
        overlap_d    = overlap_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        detected_d   = 1'b0;
        cnt_d        = cnt_q;
        match_s      = 1'b0;
        mask_s       = {MAX_LEN{1'b0}};
        hist_shift_s = {hist_q[MAX_LEN-2:0], bus.in_bit};

        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LEN_W'(i) < len_q);
        end

        if (fill_q < len_q) begin
            fill_inc_s = fill_q + LEN_W'(1);
        end else begin
            fill_inc_s = len_q;
        end

        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            overlap_d = bus.cfg_overlap;
            hist_d    = {MAX_LEN{1'b0}};
            fill_d    = {LEN_W{1'b0}};
            if (bus.cfg_len == {LEN_W{1'b0}}) begin
                len_d = LEN_W'(1);
            end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
                len_d = LEN_W'(MAX_LEN);
            end else begin
                len_d = bus.cfg_len;
            end
        end else if (bus.in_valid) begin
            match_s    = (fill_inc_s >= len_q) &&
                         (((hist_shift_s ^ pattern_q) & mask_s) == {MAX_LEN{1'b0}});
            detected_d = match_s;
            // Non-overlap: a match consumes its bits, so collection starts afresh.
            if (match_s && !overlap_q) begin
                hist_d = {MAX_LEN{1'b0}};
                fill_d = {LEN_W{1'b0}};
            end else begin
                hist_d = hist_shift_s;
                fill_d = fill_inc_s;
            end
        end else begin
            detected_d = 1'b0;
        end

        if (bus.cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        armed_d = (fill_d == len_d);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pattern_q  <= DEF_PATTERN;
            len_q      <= LEN_W'(DEF_LEN);
            overlap_q  <= DEF_OVERLAP;
            hist_q     <= {MAX_LEN{1'b0}};
            fill_q     <= {LEN_W{1'b0}};
            detected_q <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            detected_q <= detected_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.detected  = detected_q;
    assign bus.armed     = armed_q;
    assign bus.match_cnt = cnt_q;
endmodule
